// File: rtl/plru_8way.sv
// plru_8way: per-set 7-node tree pseudo-LRU for an 8-way cache.
// Tracks recency on hits/refills and returns a registered victim way,
// preferring the lowest invalid way when the set is not full.
module plru_8way #(
  parameter int SET_NUM     = 64,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   access_valid,
  input  logic [INDEX_WIDTH-1:0] access_index,
  input  logic [2:0]             access_way,
  input  logic                   victim_req,
  input  logic [INDEX_WIDTH-1:0] victim_index,
  input  logic [7:0]             valid_mask,
  output logic                   victim_valid,
  output logic [2:0]             victim_way
);

  // Node layout per set: bit 0 root, bits 1-2 level 1, bits 3-6 level 2.
  // A node value of 1 points the victim search at the upper half.
  logic [6:0] tree [SET_NUM];

  logic [6:0] acc_tree;
  logic [6:0] acc_next;
  logic [2:0] acc_n1;
  logic [2:0] acc_n2;

  logic [6:0] vic_tree;
  logic       v2;
  logic       v1;
  logic       v0;
  logic [2:0] vic_n2;
  logic [2:0] tree_way;
  logic [2:0] mask_way;
  logic [2:0] sel_way;

  // Next tree value for the accessed set: point every node on its path away from it.
  always_comb begin
    acc_tree = tree[access_index];
    acc_next = acc_tree;
    acc_n1   = 3'd1 + {2'b00, access_way[2]};
    acc_n2   = 3'd3 + {1'b0, access_way[2], access_way[1]};
    acc_next[0]      = ~access_way[2];
    acc_next[acc_n1] = ~access_way[1];
    acc_next[acc_n2] = ~access_way[0];
  end

  // Victim selection from the pre-update tree, overridden by any invalid way.
  always_comb begin
    vic_tree = tree[victim_index];
    v2       = vic_tree[0];
    v1       = v2 ? vic_tree[2] : vic_tree[1];
    vic_n2   = 3'd3 + {1'b0, v2, v1};
    v0       = vic_tree[vic_n2];
    tree_way = {v2, v1, v0};
    mask_way = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!valid_mask[i]) mask_way = 3'(i);
    end
    sel_way = (valid_mask != 8'hFF) ? mask_way : tree_way;
  end

  // Tree state storage: cleared on reset, one set updated per reported access.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int s = 0; s < SET_NUM; s++) tree[s] <= '0;
    end else if (access_valid) begin
      tree[access_index] <= acc_next;
    end
  end

  // Registered victim response; way holds between requests.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      victim_valid <= 1'b0;
      victim_way   <= 3'd0;
    end else begin
      victim_valid <= victim_req;
      if (victim_req) victim_way <= sel_way;
    end
  end

endmodule

// File: tb/tb_plru_8way.sv
// tb_plru_8way: scenario tasks plus randomized traffic against a path-walk tree model.
module tb_plru_8way;

  localparam int SET_NUM = 64;
  localparam int IW      = 6;

  logic          clk = 1'b0;
  logic          resetn;
  logic          access_valid;
  logic [IW-1:0] access_index;
  logic [2:0]    access_way;
  logic          victim_req;
  logic [IW-1:0] victim_index;
  logic [7:0]    valid_mask;
  logic          victim_valid;
  logic [2:0]    victim_way;

  int vectors    = 0;
  int miscompares = 0;

  // Reference: heap-ordered node bits per set; children of node n are 2n+1 and 2n+2.
  bit   ref_node [SET_NUM][7];
  logic exp_valid;
  logic [2:0] exp_way;

  plru_8way #(.SET_NUM(SET_NUM), .INDEX_WIDTH(IW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .access_valid (access_valid),
    .access_index (access_index),
    .access_way   (access_way),
    .victim_req   (victim_req),
    .victim_index (victim_index),
    .valid_mask   (valid_mask),
    .victim_valid (victim_valid),
    .victim_way   (victim_way)
  );

  always #5 clk = ~clk;

  function automatic int ref_victim(int set, logic [7:0] mask);
    int node;
    int way;
    if (mask != 8'hFF) begin
      for (int i = 0; i < 8; i++) if (!mask[i]) return i;
    end
    node = 0;
    way  = 0;
    for (int lvl = 0; lvl < 3; lvl++) begin
      int b;
      b    = ref_node[set][node] ? 1 : 0;
      way  = way * 2 + b;
      node = 2 * node + 1 + b;
    end
    return way;
  endfunction

  task automatic ref_touch(int set, int way);
    int node;
    node = 0;
    for (int lvl = 2; lvl >= 0; lvl--) begin
      int b;
      b = (way >> lvl) & 1;
      ref_node[set][node] = (b == 0);
      node = 2 * node + 1 + b;
    end
  endtask

  // Advance the model for the inputs now on the pins, then clock and settle.
  task automatic apply();
    if (!resetn) begin
      for (int s = 0; s < SET_NUM; s++)
        for (int n = 0; n < 7; n++) ref_node[s][n] = 1'b0;
      exp_valid = 1'b0;
      exp_way   = 3'd0;
    end else begin
      exp_valid = victim_req;
      if (victim_req) exp_way = 3'(ref_victim(int'(victim_index), valid_mask));
      if (access_valid) ref_touch(int'(access_index), int'(access_way));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    resetn       = 1'b1;
    access_valid = 1'b0;
    access_index = '0;
    access_way   = '0;
    victim_req   = 1'b0;
    victim_index = '0;
    valid_mask   = 8'hFF;
  endtask

  task automatic access(int set, int way);
    idle();
    access_valid = 1'b1;
    access_index = IW'(set);
    access_way   = 3'(way);
    apply();
  endtask

  task automatic request(int set, logic [7:0] mask);
    idle();
    victim_req   = 1'b1;
    victim_index = IW'(set);
    valid_mask   = mask;
    apply();
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    apply();
    apply();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    apply();
    vectors++;
    if (victim_valid !== 1'b0 || victim_way !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b way=%0d, want valid=0 way=0", victim_valid, victim_way);
    end
    request(5, 8'hFF);
    vectors++;
    if (victim_valid !== 1'b1 || victim_way !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_set5: valid=%b way=%0d, want valid=1 way=0", victim_valid, victim_way);
    end
    for (int k = 0; k < 4; k++) begin
      int s;
      s = int'($urandom_range(SET_NUM - 1));
      request(s, 8'hFF);
      vectors++;
      if (victim_valid !== 1'b1 || victim_way !== 3'd0) begin
        miscompares++;
        $display("FAIL reset_any_set: set=%0d valid=%b way=%0d, want 1/0", s, victim_valid, victim_way);
      end
    end
    idle();
    apply();
    vectors++;
    if (victim_valid !== 1'b0 || victim_way !== 3'd0) begin
      miscompares++;
      $display("FAIL hold_way: valid=%b way=%0d, want valid=0 way=0", victim_valid, victim_way);
    end
  endtask

  task automatic test_tree_update();
    do_reset();
    access(3, 0);
    request(3, 8'hFF);
    vectors++;
    if (victim_way !== 3'd4 || victim_way !== exp_way) begin
      miscompares++;
      $display("FAIL set3_after_way0: got %0d, want 4", victim_way);
    end
    access(3, 4);
    request(3, 8'hFF);
    vectors++;
    if (victim_way !== 3'd2) begin
      miscompares++;
      $display("FAIL set3_after_way4: got %0d, want 2", victim_way);
    end
    for (int w = 0; w < 8; w++) access(7, w);
    request(7, 8'hFF);
    vectors++;
    if (victim_way !== 3'd0) begin
      miscompares++;
      $display("FAIL set7_sweep: got %0d, want 0", victim_way);
    end
    request(8, 8'hFF);
    vectors++;
    if (victim_way !== 3'd0) begin
      miscompares++;
      $display("FAIL set8_untouched: got %0d, want 0", victim_way);
    end
  endtask

  task automatic test_mask();
    access(2, 1);
    access(2, 6);
    request(2, 8'b1111_0101);
    vectors++;
    if (victim_way !== 3'd1) begin
      miscompares++;
      $display("FAIL mask_f5: got %0d, want 1", victim_way);
    end
    request(2, 8'h00);
    vectors++;
    if (victim_way !== 3'd0) begin
      miscompares++;
      $display("FAIL mask_00: got %0d, want 0", victim_way);
    end
    request(2, 8'h7F);
    vectors++;
    if (victim_way !== 3'd7) begin
      miscompares++;
      $display("FAIL mask_7f: got %0d, want 7", victim_way);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    idle();
    access_valid = 1'b1;
    access_index = IW'(1);
    access_way   = 3'd0;
    victim_req   = 1'b1;
    victim_index = IW'(1);
    apply();
    vectors++;
    if (victim_valid !== 1'b1 || victim_way !== 3'd0) begin
      miscompares++;
      $display("FAIL same_cycle_pre: valid=%b way=%0d, want 1/0", victim_valid, victim_way);
    end
    request(1, 8'hFF);
    vectors++;
    if (victim_way !== 3'd4) begin
      miscompares++;
      $display("FAIL same_cycle_post: got %0d, want 4", victim_way);
    end
  endtask

  task automatic test_reset_mid();
    access(9, 5);
    access(9, 2);
    idle();
    resetn       = 1'b0;
    access_valid = 1'b1;
    access_index = IW'(9);
    access_way   = 3'd3;
    victim_req   = 1'b1;
    victim_index = IW'(9);
    apply();
    idle();
    apply();
    vectors++;
    if (victim_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_pulse: valid=%b, want 0", victim_valid);
    end
    request(9, 8'hFF);
    vectors++;
    if (victim_valid !== 1'b1 || victim_way !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_mid_set9: valid=%b way=%0d, want 1/0", victim_valid, victim_way);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      idle();
      victim_req   = 1'b1;
      victim_index = IW'(k % 4);
      access_valid = 1'b1;
      access_index = IW'((k + 1) % 4);
      access_way   = 3'($urandom_range(7));
      apply();
      vectors++;
      if (victim_valid !== 1'b1 || victim_way !== exp_way) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: valid=%b way=%0d, want 1/%0d", k, victim_valid, victim_way, exp_way);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      resetn       = ($urandom_range(99) != 0);
      access_valid = $urandom_range(1);
      access_index = IW'($urandom_range(5));
      access_way   = 3'($urandom_range(7));
      victim_req   = $urandom_range(1);
      victim_index = IW'($urandom_range(5));
      valid_mask   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
      apply();
      vectors++;
      if (victim_valid !== exp_valid || victim_way !== exp_way) begin
        miscompares++;
        $display("FAIL random[%0d]: valid=%b way=%0d, want %b/%0d", k, victim_valid, victim_way, exp_valid, exp_way);
      end
    end
  endtask

  initial begin
    idle();
    exp_valid = 1'b0;
    exp_way   = 3'd0;
    test_reset();
    test_tree_update();
    test_mask();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
